// File: rtl/mvau_defn.sv
// mvau_defn: shared sizes, activation word type and feeder state encoding for the MVAU activation path
package mvau_defn;
    localparam int SIMD    = 2;
    localparam int PE      = 2;
    localparam int TI      = 4;
    localparam int MatrixW = 8;
    localparam int MatrixH = 4;
    localparam int SF      = MatrixW / SIMD;
    localparam int NF      = MatrixH / PE;
    localparam int SF_W    = (SF > 1) ? $clog2(SF) : 1;
    localparam int NF_W    = (NF > 1) ? $clog2(NF) : 1;
    typedef logic [SIMD*TI-1:0] act_word_t;
    typedef enum logic {WRITE, READ} feeder_state_t;
endpackage

// File: rtl/mvu_act_buf.sv
// mvu_act_buf: SF-deep activation vector store, synchronous write, combinational read
module mvu_act_buf
    import mvau_defn::*;
(
    input  logic            clk,
    input  logic            we,
    input  logic [SF_W-1:0] waddr,
    input  logic [SIMD*TI-1:0] wdata,
    input  logic [SF_W-1:0] raddr,
    output logic [SIMD*TI-1:0] rdata
);
    act_word_t mem_q [SF];

    // capture each first-fold word so later folds can replay it
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/mvu_act_feeder.sv
// mvu_act_feeder: stores one input vector and replays it NF times to the SIMD lanes (optional MVU_ACT_FEEDER_STATS_EN adds stall/vector counters)
module mvu_act_feeder
    import mvau_defn::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_v,
    input  logic [SIMD*TI-1:0] in_act,
    output logic               in_rdy,
    input  logic               out_rdy,
    output logic               out_v,
    output logic [SIMD*TI-1:0] out_act,
    output logic               out_sf_first,
    output logic               out_sf_last
`ifdef MVU_ACT_FEEDER_STATS_EN
    ,
    output logic [31:0]        stall_cnt,
    output logic [31:0]        vec_cnt
`endif
);
    if (MatrixW % SIMD != 0 || MatrixH % PE != 0) begin : g_bad_cfg
        $error("mvu_act_feeder: MatrixW must divide by SIMD and MatrixH by PE");
    end

    feeder_state_t   state_q, state_d;
    logic [SF_W-1:0] sf_cnt_q, sf_cnt_d;
    logic [NF_W-1:0] nf_cnt_q, nf_cnt_d;
    logic            out_v_q, out_v_d;
    act_word_t       out_act_q, out_act_d;
    logic            first_q, first_d;
    logic            last_q, last_d;
    act_word_t       rd_data;
    logic            adv, load, sf_wrap, nf_last;

    assign adv     = !out_v_q || out_rdy;
    assign in_rdy  = rst && (state_q == WRITE) && adv;
    assign load    = (state_q == WRITE) ? (in_v && in_rdy) : adv;
    assign sf_wrap = sf_cnt_q == SF_W'(SF - 1);
    assign nf_last = nf_cnt_q == NF_W'(NF - 1);

    mvu_act_buf u_buf (
        .clk   (clk),
        .we    (load && (state_q == WRITE)),
        .waddr (sf_cnt_q),
        .wdata (in_act),
        .raddr (sf_cnt_q),
        .rdata (rd_data)
    );

    // next state: load the output register from the input (first fold) or the buffer (replay folds)
    always_comb begin
        state_d   = state_q;
        sf_cnt_d  = sf_cnt_q;
        nf_cnt_d  = nf_cnt_q;
        out_v_d   = out_v_q;
        out_act_d = out_act_q;
        first_d   = first_q;
        last_d    = last_q;
        if (load) begin
            out_act_d = (state_q == WRITE) ? in_act : rd_data;
            out_v_d   = 1'b1;
            first_d   = sf_cnt_q == '0;
            last_d    = sf_wrap;
            sf_cnt_d  = sf_wrap ? '0 : sf_cnt_q + 1'b1;
            if (sf_wrap) begin
                if (state_q == WRITE) begin
                    state_d  = (NF == 1) ? WRITE : READ;
                    nf_cnt_d = (NF == 1) ? '0 : NF_W'(1);
                end else begin
                    state_d  = nf_last ? WRITE : READ;
                    nf_cnt_d = nf_last ? '0 : nf_cnt_q + 1'b1;
                end
            end
        end else if (adv) begin
            out_v_d = 1'b0;
        end
    end

    // state, counters and output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= WRITE;
            sf_cnt_q  <= '0;
            nf_cnt_q  <= '0;
            out_v_q   <= 1'b0;
            out_act_q <= '0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sf_cnt_q  <= sf_cnt_d;
            nf_cnt_q  <= nf_cnt_d;
            out_v_q   <= out_v_d;
            out_act_q <= out_act_d;
            first_q   <= first_d;
            last_q    <= last_d;
        end
    end

    assign out_v        = out_v_q;
    assign out_act      = out_act_q;
    assign out_sf_first = first_q;
    assign out_sf_last  = last_q;

`ifdef MVU_ACT_FEEDER_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] vec_cnt_q, vec_cnt_d;
    logic        fin_q, fin_d;

    // fin marks the word that closes the final fold; both counters saturate
    always_comb begin
        fin_d       = load ? (sf_wrap && ((state_q == READ) ? nf_last : (NF == 1))) : fin_q;
        stall_cnt_d = stall_cnt_q + {31'd0, out_v_q && !out_rdy && !(&stall_cnt_q)};
        vec_cnt_d   = vec_cnt_q + {31'd0, out_v_q && out_rdy && fin_q && !(&vec_cnt_q)};
    end

    // statistics registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fin_q       <= 1'b0;
            stall_cnt_q <= '0;
            vec_cnt_q   <= '0;
        end else begin
            fin_q       <= fin_d;
            stall_cnt_q <= stall_cnt_d;
            vec_cnt_q   <= vec_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign vec_cnt   = vec_cnt_q;
`endif
endmodule
